// File: rtl/serial_shifter_pkg.sv
// shifter_pkg: constants and helpers shared by the serial shift unit, the
// single-cycle barrel shifter and the operand decode logic.
//   SH_*       : ARMv7 shift-type encodings (Type field)
//   state_t    : serial shift FSM state encoding
//   MAX_STEPS  : worst-case serial iteration count
//   calc_steps : iteration count for a given amount/type
package shifter_pkg;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int MAX_STEPS = 33;
  localparam int CNT_W     = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // LSL/LSR/ASR saturate at 33: one step past the word width already gives
  // the final value (zero, or sign fill) and the final carry.
  // ROR only needs amount mod 32; a non-zero multiple of 32 still takes a
  // full turn, leaving carry = bit 31.
  function automatic logic [CNT_W-1:0] calc_steps(input logic [7:0] amt,
                                                   input logic [1:0] typ,
                                                   input logic       rrx_en);
    logic [CNT_W-1:0] n;
    if (typ == SH_ROR) begin
      if (amt == 8'd0)            n = rrx_en ? CNT_W'(1) : CNT_W'(0);
      else if (amt[4:0] == 5'd0)  n = CNT_W'(32);
      else                        n = CNT_W'(amt[4:0]);
    end else begin
      n = (amt > 8'd33) ? CNT_W'(MAX_STEPS) : CNT_W'(amt);
    end
    return n;
  endfunction
endpackage

// File: rtl/serial_shifter_if.sv
// serial_shifter_if: request/result handshake bundle of the serial shifter.
//   slave  : the shift unit (accepts requests, produces results)
//   master : the execute pipeline driving requests and consuming results
interface serial_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             InValid;
  logic             InReady;
  logic [AMT_W-1:0] Amount;
  logic [1:0]       Type;
  logic [WIDTH-1:0] In;
  logic             CarryIn;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;
  logic             CarryOut;
  logic             Busy;

  modport slave (
    input  InValid, Amount, Type, In, CarryIn, OutReady,
    output InReady, OutValid, Out, CarryOut, Busy
  );

  modport master (
    output InValid, Amount, Type, In, CarryIn, OutReady,
    input  InReady, OutValid, Out, CarryOut, Busy
  );
endinterface

// File: rtl/serial_shifter_step.sv
// shift_step: combinational single-bit shift step.
//   i_data/i_carry : current value and carry
//   i_type         : SH_LSL/SH_LSR/SH_ASR/SH_ROR
//   i_rrx          : ROR step fills bit 31 from i_carry instead of bit 0
//   o_data/o_carry : value and carry after one bit position
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_carry,
  input  logic [1:0]       i_type,
  input  logic             i_rrx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);
  always_comb begin
    o_data  = i_data;
    o_carry = i_data[0];
    case (i_type)
      SH_LSL: begin
        o_carry = i_data[WIDTH-1];
        o_data  = {i_data[WIDTH-2:0], 1'b0};
      end
      SH_LSR:  o_data = {1'b0, i_data[WIDTH-1:1]};
      SH_ASR:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      default: o_data = {(i_rrx ? i_carry : i_data[0]), i_data[WIDTH-1:1]};
    endcase
  end
endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle ARMv7 register-specified shift unit, one bit
// position per clock, with shifter carry-out for the flag logic.
//   CLK, Reset : clock, synchronous active-high reset
//   bus        : serial_shifter_if.slave (request In/Amount/Type/CarryIn with
//                InValid/InReady, result Out/CarryOut with OutValid/OutReady,
//                Busy while a request is in flight)
// Build option: SERIAL_SHIFTER_RRX_EN makes ROR #0 perform RRX (one step
// filling bit 31 from CarryIn); otherwise ROR #0 is a passthrough.
module serial_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input logic        CLK,
  input logic        Reset,
  serial_shifter_if.slave bus
);
`ifdef SERIAL_SHIFTER_RRX_EN
  localparam logic RRX_EN = 1'b1;
`else
  localparam logic RRX_EN = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic [1:0]       r_type;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rrx;
  logic             r_ready;

  logic             w_accept;
  logic [CNT_W-1:0] w_steps;
  logic             w_rrx_ld;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;

  // r_ready mirrors "state is IDLE and not in reset" as a register so that
  // InReady stays low throughout a reset without a path from the Reset pin.
  assign w_accept = bus.InValid && r_ready;
  assign w_steps  = calc_steps(8'(bus.Amount), bus.Type, RRX_EN);
  assign w_rrx_ld = RRX_EN && (bus.Type == SH_ROR) && (bus.Amount == '0);

  // During an RRX step r_carry still holds CarryIn, so it is the fill bit.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data  (r_data),
    .i_carry (r_carry),
    .i_type  (r_type),
    .i_rrx   (r_rrx),
    .o_data  (w_step_data),
    .o_carry (w_step_carry)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (w_steps == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (bus.OutReady) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_type  <= SH_LSL;
      r_cnt   <= '0;
      r_rrx   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_data  <= bus.In;
          r_carry <= bus.CarryIn;
          r_type  <= bus.Type;
          r_cnt   <= w_steps;
          r_rrx   <= w_rrx_ld;
        end
        ST_SHIFT: begin
          r_data  <= w_step_data;
          r_carry <= w_step_carry;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.InReady  = r_ready;
  assign bus.OutValid = (r_state == ST_DONE);
  assign bus.Busy     = (r_state != ST_IDLE);
  assign bus.Out      = r_data;
  assign bus.CarryOut = r_carry;
endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;
  import shifter_pkg::*;

`ifdef SERIAL_SHIFTER_RRX_EN
  localparam bit RRX = 1'b1;
`else
  localparam bit RRX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_shifter_if #(.WIDTH(32), .AMT_W(8)) bus ();

  serial_shifter #(.WIDTH(32), .AMT_W(8)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ARM shift-by-register semantics computed arithmetically; n is the
  // cycle count from accept edge to first OutValid cycle.
  function automatic void model(input logic [31:0] a, input logic [7:0] amt,
                                input logic [1:0] t, input logic cin,
                                output logic [31:0] o, output logic c, output int n);
    int r;
    o = a; c = cin;
    if (amt == 0) begin
      n = 1;
      if (t == 2'b11 && RRX) begin
        o = {cin, a[31:1]}; c = a[0]; n = 2;
      end
      return;
    end
    case (t)
      2'b00: begin
        n = (amt > 33) ? 34 : amt + 1;
        if (amt < 32)       begin o = a << amt; c = a[32-amt]; end
        else if (amt == 32) begin o = 0; c = a[0]; end
        else                begin o = 0; c = 0; end
      end
      2'b01: begin
        n = (amt > 33) ? 34 : amt + 1;
        if (amt < 32)       begin o = a >> amt; c = a[amt-1]; end
        else if (amt == 32) begin o = 0; c = a[31]; end
        else                begin o = 0; c = 0; end
      end
      2'b10: begin
        n = (amt > 33) ? 34 : amt + 1;
        if (amt < 32) begin o = 32'($signed(a) >>> amt); c = a[amt-1]; end
        else          begin o = {32{a[31]}}; c = a[31]; end
      end
      default: begin
        r = amt % 32;
        if (r == 0) begin o = a; c = a[31]; n = 33; end
        else begin o = (a >> r) | (a << (32 - r)); c = o[31]; n = r + 1; end
      end
    endcase
  endfunction

  // One request; hold > 0 keeps OutReady low for that many DONE cycles.
  task automatic do_req(input logic [31:0] a, input logic [7:0] amt,
                        input logic [1:0] t, input logic cin, input int hold);
    logic [31:0] eo, so; logic ec, sc; int en, lat, w;
    model(a, amt, t, cin, eo, ec, en);
    w = 0;
    while (bus.InReady !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("inready_wait", 64'(w < 50), 64'd1);
    bus.OutReady = (hold == 0);
    bus.InValid = 1'b1; bus.In = a; bus.Amount = amt; bus.Type = t; bus.CarryIn = cin;
    @(posedge clk); #1;
    lat = 0;
    do begin
      bus.InValid = 1'($urandom); bus.In = $urandom; bus.Amount = 8'($urandom);
      bus.Type = 2'($urandom); bus.CarryIn = 1'($urandom);
      @(negedge clk); lat++;
    end while (bus.OutValid !== 1'b1 && lat < 40);
    chk($sformatf("lat t%0d a%0d", t, amt), 64'(lat), 64'(en));
    chk($sformatf("out t%0d a%0d in%0h", t, amt, a), 64'(bus.Out), 64'(eo));
    chk($sformatf("cout t%0d a%0d in%0h", t, amt, a), 64'(bus.CarryOut), 64'(ec));
    if (hold == 0) begin
      bus.InValid = 1'b0;
      @(negedge clk);
      chk("ov_one_cycle", 64'(bus.OutValid), 64'd0);
      chk("ready_after", 64'(bus.InReady), 64'd1);
    end else begin
      so = bus.Out; sc = bus.CarryOut;
      for (int i = 0; i < hold; i++) begin
        bus.InValid = 1'b1; bus.In = $urandom;
        @(negedge clk);
        chk("bp_out", 64'(bus.Out), 64'(so));
        chk("bp_cout", 64'(bus.CarryOut), 64'(sc));
        chk("bp_ov", 64'(bus.OutValid), 64'd1);
        chk("bp_inready", 64'(bus.InReady), 64'd0);
      end
      bus.OutReady = 1'b1;          // InValid stays high across the handshake
      @(negedge clk);
      chk("bp_ov_drop", 64'(bus.OutValid), 64'd0);
      chk("bp_no_reaccept", 64'(bus.Busy), 64'd0);
      chk("bp_ready", 64'(bus.InReady), 64'd1);
      bus.InValid = 1'b0;
    end
  endtask

  initial begin
    int seen;
    logic [7:0] amt;
    bus.InValid = 0; bus.OutReady = 1; bus.In = 0; bus.Amount = 0;
    bus.Type = 0; bus.CarryIn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inready", 64'(bus.InReady), 64'd0);
    chk("rst_ov", 64'(bus.OutValid), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_out", 64'(bus.Out), 64'd0);
    chk("rst_cout", 64'(bus.CarryOut), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rel_inready", 64'(bus.InReady), 64'd1);

    // directed boundary cases
    do_req(32'h8000_0001, 8'd1,   SH_LSL, 1'b0, 0);
    do_req(32'h8000_0000, 8'd32,  SH_LSR, 1'b0, 0);
    do_req(32'h8000_0000, 8'd200, SH_LSR, 1'b1, 0);
    do_req(32'h0000_0001, 8'd32,  SH_LSL, 1'b0, 0);
    do_req(32'hFFFF_FFFF, 8'd33,  SH_LSL, 1'b1, 0);
    do_req(32'hF000_0000, 8'd40,  SH_ASR, 1'b0, 0);
    do_req(32'h7000_0000, 8'd32,  SH_ASR, 1'b1, 0);
    do_req(32'h1234_5678, 8'd64,  SH_ROR, 1'b1, 0);
    do_req(32'h8765_4321, 8'd32,  SH_ROR, 1'b0, 0);
    do_req(32'h0000_0003, 8'd0,   SH_ROR, 1'b1, 0);
    do_req(32'h0000_0002, 8'd0,   SH_ROR, 1'b0, 0);
    do_req(32'hDEAD_BEEF, 8'd0,   SH_LSL, 1'b1, 0);
    do_req(32'hCAFE_F00D, 8'd7,   SH_ROR, 1'b0, 5);
    do_req(32'h0000_0001, 8'd0,   SH_LSR, 1'b0, 3);

    // reset in the middle of a 33-step LSL
    bus.OutReady = 1'b1;
    bus.InValid = 1'b1; bus.In = 32'hFFFF_FFFF; bus.Amount = 8'd40;
    bus.Type = SH_LSL; bus.CarryIn = 1'b1;
    @(posedge clk); #1 bus.InValid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(bus.Busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_ov", 64'(bus.OutValid), 64'd0);
    chk("mr_out", 64'(bus.Out), 64'd0);
    chk("mr_cout", 64'(bus.CarryOut), 64'd0);
    chk("mr_busy", 64'(bus.Busy), 64'd0);
    chk("mr_inready", 64'(bus.InReady), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rel_ready", 64'(bus.InReady), 64'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.OutValid === 1'b1) seen++; end
    chk("mr_no_result", 64'(seen), 64'd0);
    do_req(32'h0000_00F0, 8'd4, SH_LSR, 1'b0, 0);

    // randomized
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0:       amt = 8'($urandom_range(30, 34));
        1:       amt = 8'($urandom_range(0, 2));
        2:       amt = 8'(32 * $urandom_range(0, 7));
        default: amt = 8'($urandom);
      endcase
      do_req($urandom, amt, 2'($urandom), 1'($urandom),
             ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle, handshaked ARMv7 shift unit implementing register-specified shift semantics (LSL/LSR/ASR/ROR with 8-bit amounts, plus carry-out), one bit position per clock. It sits beside the single-cycle barrel shifter, serves shift-by-register operands and the multi-cycle execute path, and supplies the shifter carry-out consumed by the flag logic.

## Interface
- WIDTH, 32, data width
- AMT_W, 8, shift-amount width (Rs[7:0])
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- InValid  input  1  request valid
- InReady  output  1  unit can accept a request
- Amount  input  AMT_W  shift amount, 0–255
- Type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- In  input  WIDTH  operand
- CarryIn  input  1  current C flag
- OutValid  output  1  result valid
- OutReady  input  1  consumer accepts result
- Out  output  WIDTH  shifted result
- CarryOut  output  1  shifter carry-out
- Busy  output  1  request in flight (SHIFT or DONE)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: InReady=1. On InValid&&InReady, register In, Type, CarryIn; load iteration count N; go to SHIFT if N>0, else DONE with Out=In, CarryOut=CarryIn.
- N: LSL/LSR/ASR → min(Amount, 33); ROR → 0 if Amount==0, 32 if Amount[4:0]==0, else Amount[4:0].
- SHIFT: one step per cycle, count decrements; last step (count==1) moves to DONE.
  - LSL: carry←data[31], data←{data[30:0],0}
  - LSR: carry←data[0], data←{0,data[31:1]}
  - ASR: carry←data[0], data←{data[31],data[31:1]}
  - ROR: carry←data[0], data←{data[0],data[31:1]}
- Resulting ARM boundary behaviour (required): LSL/LSR by 32 → Out=0, C=In[0] / In[31]; by >32 → Out=0, C=0. ASR ≥32 → all bits and C = In[31]. ROR by 32, 64, … → Out=In, C=In[31].
- DONE: OutValid=1, Out/CarryOut stable until OutValid&&OutReady; then IDLE.
- Inputs are ignored while not in IDLE; request inputs need to be stable only in the accept cycle.

## Timing
- Accept at edge k → OutValid high from cycle k+1+N (N=0 → k+1). Worst case 33 steps (LSL/LSR/ASR ≥33, or ROR by 32).
- Result handshake at edge m → IDLE after m, InReady=1 in cycle m+1; no same-cycle re-accept.
- OutReady held high at DONE entry: result still visible for exactly one cycle.
- Reset (any state, including mid-SHIFT or DONE): next cycle state IDLE, Out=0, CarryOut=0, OutValid=0, Busy=0; InReady=0 while Reset is high, 1 on the first cycle after release. In-flight request discarded, no output.
- InReady, OutValid, Busy decode from registered state only; no input-to-output combinational paths.

## Configuration
- SERIAL_SHIFTER_RRX_EN defined: Type=11 with Amount==0 performs RRX: N=1, step is data←{CarryIn,data[31:1]}, carry←data[0]; latency k+2.
- Not defined: Type=11 with Amount==0 is a passthrough (Out=In, CarryOut=CarryIn, latency k+1), same as other types.

## Structure
- Package shifter_pkg: shift-type constants SH_LSL/SH_LSR/SH_ASR/SH_ROR, FSM state encoding, constant MAX_STEPS=33; shared with the combinational shifter and decode logic.
- One sub-module: shift_step, combinational one-bit step (data, carry, type, rrx fill in → data, carry out), instantiated once in the SHIFT datapath.

## Test plan
- LSL, In=32'h8000_0001, Amount=1, CarryIn=0 → Out=32'h0000_0002, C=1, OutValid at k+2.
- LSR by 32 with In=32'h8000_0000 → Out=0, C=1; LSR by 200 → Out=0, C=0, OutValid at k+34.
- ASR, In=32'hF000_0000, Amount=40 → Out=32'hFFFF_FFFF, C=1; ROR, In=32'h1234_5678, Amount=64 → Out=In, C=0.
- Amount=0, Type=ROR, In=32'h0000_0003, CarryIn=1 → RRX_EN: Out=32'h8000_0001, C=1 at k+2; without: Out=32'h0000_0003, C=1 at k+1.
- Backpressure: OutReady low for 5 cycles in DONE → Out/CarryOut stable, InValid ignored, InReady=0; accepted one cycle after OutReady rises.
- Reset pulsed during SHIFT of a 33-step LSL → next cycle OutValid=0, Out=0, Busy=0; no result emitted; new request accepted normally afterwards.
